// File: rtl/axil_pkg.sv
// Shared types for the AXI-lite command master: FSM state encoding and AXI response codes.
package axil_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_DATA,
      ST_RSP
   } axil_state_e;

   typedef enum logic [1:0] {
      AXI_OKAY   = 2'b00,
      AXI_EXOKAY = 2'b01,
      AXI_SLVERR = 2'b10,
      AXI_DECERR = 2'b11
   } axil_resp_e;

endpackage

// File: rtl/axil_master_wdog.sv
// Watchdog for the command master: counts cycles while run is high and flags the last allowed cycle.
module axil_master_wdog #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt;

   // clear marks the first cycle in a new state; that cycle already counts as one
   assign w_cnt   = clear ? '0 : r_cnt;
   assign expired = run && (w_cnt == CW'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (!resetn || !run) r_cnt <= '0;
      else                 r_cnt <= w_cnt + 1'b1;
   end

endmodule

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-lite master driven by a simple command/response port.
// Optional watchdog abort is built when AXIL_MASTER_TIMEOUT_EN is defined.
module axil_cmd_master #(
   parameter int          ADDR_W      = 8,
   parameter int          DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                  m00_axi_aclk,
   input  logic                  m00_axi_aresetn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wr,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [DATA_W-1:0]     cmd_wdata,
   input  logic [DATA_W/8-1:0]   cmd_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  rsp_timeout,
   output logic [ADDR_W-1:0]     m00_axi_awaddr,
   output logic [2:0]            m00_axi_awprot,
   output logic                  m00_axi_awvalid,
   input  logic                  m00_axi_awready,
   output logic [DATA_W-1:0]     m00_axi_wdata,
   output logic [DATA_W/8-1:0]   m00_axi_wstrb,
   output logic                  m00_axi_wvalid,
   input  logic                  m00_axi_wready,
   input  logic [1:0]            m00_axi_bresp,
   input  logic                  m00_axi_bvalid,
   output logic                  m00_axi_bready,
   output logic [ADDR_W-1:0]     m00_axi_araddr,
   output logic [2:0]            m00_axi_arprot,
   output logic                  m00_axi_arvalid,
   input  logic                  m00_axi_arready,
   input  logic [DATA_W-1:0]     m00_axi_rdata,
   input  logic [1:0]            m00_axi_rresp,
   input  logic                  m00_axi_rvalid,
   output logic                  m00_axi_rready
);
   import axil_pkg::*;

   axil_state_e           r_state;
   logic [ADDR_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W/8-1:0]   r_wstrb;
   logic                  r_awvalid;
   logic                  r_wvalid;
   logic                  r_bready;
   logic                  r_arvalid;
   logic                  r_rready;
   logic                  r_rsp_valid;
   logic [DATA_W-1:0]     r_rsp_rdata;
   logic [1:0]            r_rsp_resp;
   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_expired;

   assign w_aw_hs = r_awvalid && m00_axi_awready;
   assign w_w_hs  = r_wvalid && m00_axi_wready;

   // gated by reset so the port reads not-ready during the reset cycle itself
   assign cmd_ready = (r_state == ST_IDLE) && m00_axi_aresetn;

   always_ff @(posedge m00_axi_aclk) begin
      if (!m00_axi_aresetn) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= AXI_OKAY;
      end else if (w_expired) begin
         r_state     <= ST_RSP;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b1;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= AXI_SLVERR;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  r_addr  <= cmd_addr;
                  r_wdata <= cmd_wdata;
                  r_wstrb <= cmd_wstrb;
                  if (cmd_wr) begin
                     r_state   <= ST_WR_REQ;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                  end else begin
                     r_state   <= ST_RD_REQ;
                     r_arvalid <= 1'b1;
                  end
               end
            end
            ST_WR_REQ: begin
               if (w_aw_hs) r_awvalid <= 1'b0;
               if (w_w_hs)  r_wvalid  <= 1'b0;
               // a channel is done once its valid has dropped or it handshakes now
               if ((!r_awvalid || w_aw_hs) && (!r_wvalid || w_w_hs)) begin
                  r_state  <= ST_WR_RESP;
                  r_bready <= 1'b1;
               end
            end
            ST_WR_RESP: begin
               if (m00_axi_bvalid) begin
                  r_state     <= ST_RSP;
                  r_bready    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= '0;
                  r_rsp_resp  <= m00_axi_bresp;
               end
            end
            ST_RD_REQ: begin
               if (m00_axi_arready) begin
                  r_state   <= ST_RD_DATA;
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
               end
            end
            ST_RD_DATA: begin
               if (m00_axi_rvalid) begin
                  r_state     <= ST_RSP;
                  r_rready    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= m00_axi_rdata;
                  r_rsp_resp  <= m00_axi_rresp;
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  r_state     <= ST_IDLE;
                  r_rsp_valid <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef AXIL_MASTER_TIMEOUT_EN
   axil_state_e r_prev_state;
   logic        r_rsp_timeout;
   logic        w_wd_run;
   logic        w_wd_clear;

   always_ff @(posedge m00_axi_aclk) begin
      if (!m00_axi_aresetn) r_prev_state <= ST_IDLE;
      else                  r_prev_state <= r_state;
   end

   assign w_wd_run   = (r_state != ST_IDLE) && (r_state != ST_RSP);
   assign w_wd_clear = (r_state != r_prev_state);

   axil_master_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
      .clk     (m00_axi_aclk),
      .resetn  (m00_axi_aresetn),
      .clear   (w_wd_clear),
      .run     (w_wd_run),
      .expired (w_expired)
   );

   always_ff @(posedge m00_axi_aclk) begin
      if (!m00_axi_aresetn)         r_rsp_timeout <= 1'b0;
      else if (w_expired)           r_rsp_timeout <= 1'b1;
      else if (r_state == ST_IDLE)  r_rsp_timeout <= 1'b0;
   end

   assign rsp_timeout = r_rsp_timeout;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_CYC;
   assign w_expired        = 1'b0;
   assign rsp_timeout      = 1'b0;
`endif

   assign m00_axi_awaddr  = r_addr;
   assign m00_axi_awprot  = 3'b000;
   assign m00_axi_awvalid = r_awvalid;
   assign m00_axi_wdata   = r_wdata;
   assign m00_axi_wstrb   = r_wstrb;
   assign m00_axi_wvalid  = r_wvalid;
   assign m00_axi_bready  = r_bready;
   assign m00_axi_araddr  = r_addr;
   assign m00_axi_arprot  = 3'b000;
   assign m00_axi_arvalid = r_arvalid;
   assign m00_axi_rready  = r_rready;
   assign rsp_valid       = r_rsp_valid;
   assign rsp_rdata       = r_rsp_rdata;
   assign rsp_resp        = r_rsp_resp;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Scoreboard bench for axil_cmd_master with a delay-programmable AXI-lite slave model.
`timescale 1ns/1ps
module tb_axil_cmd_master;
   import axil_pkg::*;

   localparam int AW = 8, DW = 32, SW = DW/8;

   logic clk = 1'b0, rstn = 1'b0;
   always #5 clk = ~clk;

   logic cmd_valid, cmd_ready, cmd_wr, rsp_valid, rsp_ready, rsp_timeout;
   logic [AW-1:0] cmd_addr, awaddr, araddr;
   logic [DW-1:0] cmd_wdata, rsp_rdata, wdata, rdata;
   logic [SW-1:0] cmd_wstrb, wstrb;
   logic [1:0]    rsp_resp, bresp, rresp;
   logic [2:0]    awprot, arprot;
   logic awvalid, awready, wvalid, wready, bvalid, bready;
   logic arvalid, arready, rvalid, rready;

   axil_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
      .m00_axi_aclk(clk), .m00_axi_aresetn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .rsp_timeout(rsp_timeout),
      .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
      .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
      .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
      .m00_axi_araddr(araddr), .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
      .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
   );

   typedef struct { logic [DW-1:0] rdata; logic [1:0] resp; logic to; int lat; } exp_t;
   exp_t sb[$];

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // slave configuration and current-command expectations
   int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic [1:0]    b_resp_cfg = AXI_OKAY, r_resp_cfg = AXI_OKAY;
   logic [DW-1:0] r_data_cfg = '0;
   bit stray = 0, hold_en = 1;
   logic [AW-1:0] cur_addr;
   logic [DW-1:0] cur_wdata;
   logic [SW-1:0] cur_wstrb;

   // observation state
   int cyc = 0, acc_cyc = 0, aw_cyc = 0, w_cyc = 0, n_rsp = 0;
   int aw_hi = 0, w_hi = 0, ar_hi = 0;

   initial begin : slave_mon
      exp_t e;
      int aw_wait, w_wait, b_wait, ar_wait, r_wait;
      bit aw_got, w_got, b_pend, r_pend;
      bit p_aw_wait, p_w_wait, p_ar_wait, p_rsp_wait, p_rstn;
      logic [63:0] held;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      p_aw_wait = 0; p_w_wait = 0; p_ar_wait = 0; p_rsp_wait = 0; p_rstn = 0; held = '0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (hold_en && p_rstn) begin
            if (p_aw_wait) chk("aw_hold", {awvalid, awaddr}, {1'b1, cur_addr});
            if (p_w_wait)  chk("w_hold", {wvalid, wstrb, wdata}, {1'b1, cur_wstrb, cur_wdata});
            if (p_ar_wait) chk("ar_hold", {arvalid, araddr}, {1'b1, cur_addr});
         end
         if (cmd_valid && cmd_ready) begin acc_cyc = cyc; aw_hi = 0; w_hi = 0; ar_hi = 0; end
         if (awvalid) aw_hi++;
         if (wvalid)  w_hi++;
         if (arvalid) ar_hi++;
         if (awvalid && awready) begin
            chk("awaddr_prot", {awprot, awaddr}, {3'b000, cur_addr});
            aw_got = 1; aw_cyc = cyc;
         end
         if (wvalid && wready) begin
            chk("wdata", {wstrb, wdata}, {cur_wstrb, cur_wdata});
            w_got = 1; w_cyc = cyc;
         end
         if (aw_got && w_got) begin b_pend = 1; b_wait = 0; aw_got = 0; w_got = 0; end
         if (bvalid && bready) b_pend = 0;
         if (arvalid && arready) begin
            chk("araddr_prot", {arprot, araddr}, {3'b000, cur_addr});
            r_pend = 1; r_wait = 0;
         end
         if (rvalid && rready) r_pend = 0;
         if (rsp_valid) begin
            if (p_rsp_wait) begin
               chk("rsp_stable", {rsp_timeout, rsp_resp, rsp_rdata}, held);
               chk("rsp_wait_quiet", {cmd_ready, awvalid, wvalid, arvalid, bready, rready}, 6'b0);
            end else if (sb.size() == 0) begin
               chk("rsp_unexpected", rsp_valid, 0);
            end else if (sb[0].lat >= 0) begin
               chk("latency", cyc - acc_cyc, sb[0].lat);
            end
            if (rsp_ready && sb.size() > 0) begin
               e = sb.pop_front();
               chk("rsp_rdata", rsp_rdata, e.rdata);
               chk("rsp_resp", rsp_resp, e.resp);
               chk("rsp_timeout", rsp_timeout, e.to);
               n_rsp++;
            end
         end
         p_rsp_wait = rsp_valid && !rsp_ready;
         held       = {rsp_timeout, rsp_resp, rsp_rdata};
         p_aw_wait  = awvalid && !awready;
         p_w_wait   = wvalid && !wready;
         p_ar_wait  = arvalid && !arready;
         p_rstn     = rstn;

         @(posedge clk); #2;
         if (!rstn) begin
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0;
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
         end else begin
            if (awvalid) begin awready = (aw_wait >= aw_dly); aw_wait++; end
            else begin awready = 0; aw_wait = 0; end
            if (wvalid) begin wready = (w_wait >= w_dly); w_wait++; end
            else begin wready = 0; w_wait = 0; end
            if (arvalid) begin arready = (ar_wait >= ar_dly); ar_wait++; end
            else begin arready = 0; ar_wait = 0; end
            bresp = b_resp_cfg;
            if (b_pend) begin bvalid = (b_wait >= b_dly); b_wait++; end
            else bvalid = stray;
            if (r_pend) begin
               rvalid = (r_wait >= r_dly); r_wait++; rdata = r_data_cfg; rresp = r_resp_cfg;
            end else begin
               rvalid = stray; rdata = 32'hBAD0BAD0; rresp = AXI_EXOKAY;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic [DW-1:0] er, input logic [1:0] ersp,
                        input logic eto, input int lat);
      exp_t e;
      bit ok;
      e.rdata = er; e.resp = ersp; e.to = eto; e.lat = lat;
      sb.push_back(e);
      cur_addr = a; cur_wdata = d; cur_wstrb = s;
      step();
      cmd_valid = 1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1; break; end
      end
      chk("cmd_accept", ok, 1);
      step();
      cmd_valid = 0;
   endtask

   task automatic wait_rsp(input int target);
      int i = 0;
      while (n_rsp < target && i < 300) begin step(); i++; end
      chk("rsp_count", n_rsp, target);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1);
   end

   initial begin : main
      int exp_n, m, lat;
      bit wr;
      logic [DW-1:0] d;
      logic [1:0] rs;
      exp_n = 0;
      cmd_valid = 0; cmd_wr = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1;
      cur_addr = '0; cur_wdata = '0; cur_wstrb = '0;
      repeat (3) step();
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_outs", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, '0);
      step(); rstn = 1;
      @(negedge clk);
      chk("idle_cmd_ready", cmd_ready, 1);

      // always-ready write: AW and W together, 3-cycle latency
      issue(1, 8'h04, 32'hDEADBEEF, 4'hF, '0, AXI_OKAY, 0, 3);
      wait_rsp(++exp_n);
      chk("aw_w_same_cycle", aw_cyc, w_cyc);
      chk("wr_valid_cycles", {aw_hi[7:0], w_hi[7:0]}, {8'd1, 8'd1});

      // wready lags awready by 5 cycles
      w_dly = 5;
      issue(1, 8'h20, 32'hA5A50F0F, 4'b0110, '0, AXI_OKAY, 0, 8);
      wait_rsp(++exp_n);
      chk("aw_hi_once", aw_hi, 1);
      chk("w_hi_cycles", w_hi, 6);
      chk("w_after_aw", w_cyc - aw_cyc, 5);
      repeat (5) step();
      chk("single_rsp", n_rsp, exp_n);
      w_dly = 0;

      // read with delayed SLVERR data
      r_dly = 4; r_data_cfg = 32'h12345678; r_resp_cfg = AXI_SLVERR;
      issue(0, 8'h10, '0, '0, 32'h12345678, 2'b10, 0, 7);
      wait_rsp(++exp_n);

      // minimum read latency
      r_dly = 0; r_data_cfg = 32'hCAFEF00D; r_resp_cfg = AXI_OKAY;
      issue(0, 8'hFC, '0, '0, 32'hCAFEF00D, AXI_OKAY, 0, 3);
      wait_rsp(++exp_n);

      // response back-pressure for 10 cycles
      rsp_ready = 0; b_resp_cfg = AXI_DECERR;
      issue(1, 8'h44, 32'h0BADCAFE, 4'h3, '0, 2'b11, 0, 3);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      repeat (10) step();
      @(negedge clk);
      chk("rsp_held", {rsp_valid, cmd_ready}, 2'b10);
      step(); rsp_ready = 1;
      wait_rsp(++exp_n);
      b_resp_cfg = AXI_OKAY;

      // stray bvalid/rvalid while idle are ignored
      stray = 1;
      repeat (4) step();
      stray = 0;
      repeat (3) step();
      chk("stray_no_rsp", n_rsp, exp_n);
      @(negedge clk);
      chk("stray_idle", cmd_ready, 1);

      // reset while waiting for B abandons the write
      b_dly = 20;
      issue(1, 8'h08, 32'h11112222, 4'hF, '0, AXI_OKAY, 0, -1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bready) break;
      end
      chk("in_wr_resp", bready, 1);
      step(); rstn = 0; sb.delete();
      @(negedge clk);
      chk("rst_mid_cmd_ready", cmd_ready, 0);
      step(); rstn = 1;
      @(negedge clk);
      chk("post_rst_outs", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, '0);
      chk("post_rst_idle", cmd_ready, 1);
      b_dly = 0;
      r_data_cfg = 32'h0F1E2D3C;
      issue(0, 8'h30, '0, '0, 32'h0F1E2D3C, AXI_OKAY, 0, 3);
      wait_rsp(++exp_n);

`ifdef AXIL_MASTER_TIMEOUT_EN
      // slave never grants AR: abort 16 cycles after entering RD_REQ
      hold_en = 0; ar_dly = 1000;
      issue(0, 8'h50, '0, '0, '0, AXI_SLVERR, 1, 17);
      wait_rsp(++exp_n);
      chk("ar_hi_timeout", ar_hi, 16);
      ar_dly = 0; hold_en = 1;
`endif

      // random mix with independently predicted latency
      for (int k = 0; k < 10; k++) begin
         wr = 1'($urandom_range(0, 1));
         aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
         ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
         rs = 2'($urandom_range(0, 3));
         d = $urandom;
         if (wr) begin
            b_resp_cfg = rs;
            m = (aw_dly > w_dly) ? aw_dly : w_dly;
            lat = 3 + m + b_dly;
            issue(1, 8'($urandom), d, 4'($urandom), '0, rs, 0, lat);
         end else begin
            r_resp_cfg = rs; r_data_cfg = d;
            lat = 3 + ar_dly + r_dly;
            issue(0, 8'($urandom), '0, '0, d, rs, 0, lat);
         end
         wait_rsp(++exp_n);
      end

      repeat (5) step();
      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, AXI-lite address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI-lite data width; wstrb width is DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, watchdog limit in clock cycles (used only when AXIL_MASTER_TIMEOUT_EN is defined).
REQ-004 SHALL have one clock and one reset: m00_axi_aclk in 1, the only clock; m00_axi_aresetn in 1, synchronous, active-low reset.
REQ-005 SHALL have the command port: cmd_valid in 1; cmd_ready out 1; cmd_wr in 1 (1=write, 0=read); cmd_addr in ADDR_W; cmd_wdata in DATA_W; cmd_wstrb in DATA_W/8.
REQ-006 SHALL have the response port: rsp_valid out 1; rsp_ready in 1; rsp_rdata out DATA_W; rsp_resp out 2; rsp_timeout out 1.
REQ-007 SHALL have the AXI-lite master port m00_axi_*: awaddr, awprot(3), awvalid out; awready in; wdata, wstrb, wvalid out; wready in; bresp(2), bvalid in; bready out; araddr, arprot(3), arvalid out; arready in; rdata, rresp(2), rvalid in; rready out.

Function
REQ-008 SHALL implement states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
REQ-009 SHALL assert cmd_ready only in IDLE; a command is accepted on a cycle where cmd_valid && cmd_ready.
REQ-010 SHALL, on acceptance, register addr/wdata/wstrb and move to WR_REQ if cmd_wr, else RD_REQ; awprot and arprot are held at 3'b000.
REQ-011 SHALL, in WR_REQ, assert awvalid and wvalid on the cycle after acceptance, deassert each independently on its own handshake (valid && ready), and go to WR_RESP once both handshakes have occurred, including when both occur in the same cycle.
REQ-012 SHALL never deassert awvalid, wvalid or arvalid before their handshake, and hold awaddr/wdata/wstrb/araddr stable while the corresponding valid is high.
REQ-013 SHALL, in WR_RESP, assert bready; on bvalid, capture bresp into rsp_resp, set rsp_rdata to 0, and go to RSP.
REQ-014 SHALL, in RD_REQ, assert arvalid until arready, then go to RD_DATA.
REQ-015 SHALL, in RD_DATA, assert rready; on rvalid, capture rdata and rresp and go to RSP.
REQ-016 SHALL, in RSP, hold rsp_valid high with stable rsp_rdata/rsp_resp/rsp_timeout until rsp_ready, then return to IDLE.
REQ-017 SHALL accept a new command no earlier than the cycle after the rsp handshake (one outstanding transaction maximum).
REQ-018 SHALL have a minimum write latency of 3 cycles (acceptance to rsp_valid) when awready, wready and bvalid are all high immediately, and a minimum read latency of 3 cycles likewise.
REQ-019 SHALL ignore bvalid and rvalid that arrive outside WR_RESP and RD_DATA respectively.

Reset
REQ-020 SHALL, while m00_axi_aresetn is low at a clock edge, enter IDLE and drive all valid/ready outputs and rsp_timeout to 0, and rsp_rdata and rsp_resp to 0.
REQ-021 SHALL abandon an in-flight transaction on reset mid-operation without emitting a response.
REQ-022 SHALL keep cmd_ready at 0 during the cycle in which reset is sampled low.

Configuration
REQ-023 SHALL, with AXIL_MASTER_TIMEOUT_EN defined, count cycles spent in any state other than IDLE or RSP; when the count reaches TIMEOUT_CYC, drop all AXI valid/ready outputs, set rsp_resp=2'b10, rsp_rdata=0 and rsp_timeout=1, and go to RSP.
REQ-024 SHALL, with AXIL_MASTER_TIMEOUT_EN defined, clear the counter on every state transition.
REQ-025 SHALL, without AXIL_MASTER_TIMEOUT_EN, wait indefinitely, omit the counter logic, and tie rsp_timeout to 0.

Structure
REQ-026 SHALL place the state enum and the AXI response constants (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11) in the shared package axil_pkg.
REQ-027 SHALL implement the watchdog as the sub-module axil_master_wdog (inputs: clk, resetn, clear, run; output: expired), instantiated only under AXIL_MASTER_TIMEOUT_EN.

Verification
REQ-028 Write of addr 8'h04 and data 32'hDEADBEEF to an always-ready slave -> AW and W handshake in the same cycle, rsp_valid 3 cycles after acceptance with rsp_resp=00.
REQ-029 Write with wready delayed 5 cycles after awready -> awvalid drops after its handshake, wvalid is held 5 cycles, and exactly one response is produced.
REQ-030 Read of addr 8'h10 from a slave returning 32'h12345678 with rresp=2'b10 after 4 cycles -> rsp_rdata=32'h12345678 and rsp_resp=10.
REQ-031 rsp_ready held low for 10 cycles -> rsp_valid and the response fields stay stable, cmd_ready=0, and no AXI valids are asserted.
REQ-032 Reset asserted while in WR_RESP -> the next cycle is IDLE with all outputs 0, and a following read completes normally.
REQ-033 With AXIL_MASTER_TIMEOUT_EN and TIMEOUT_CYC=16, a slave that never asserts arready -> arvalid drops, rsp_timeout=1 and rsp_resp=10 appear 16 cycles after entering RD_REQ.
